// File: rtl/pe_pkg.sv
// Shared types and helpers for the fused-PE partial-sum path.
package pe_pkg;

  localparam int PROD_W_DEF = 15;
  localparam int ACC_W_DEF  = 24;
  localparam int CNT_W_DEF  = 8;
  // Widest accumulator sat_add can serve; operands arrive sign-extended to this width.
  localparam int SUM_MAX_W  = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } acc_state_e;

  typedef struct packed {
    logic                 ovf;
    logic [SUM_MAX_W-1:0] sum;
  } sat_sum_t;

  // Adds two w-bit signed values (sign-extended to SUM_MAX_W). Overflow is judged at
  // width w; the result is either clamped or wrapped to w bits and returned sign-extended.
  function automatic sat_sum_t sat_add(input logic signed [SUM_MAX_W-1:0] a,
                                       input logic signed [SUM_MAX_W-1:0] b,
                                       input int                          w,
                                       input logic                        sat_en);
    sat_sum_t                    r;
    logic signed [SUM_MAX_W-1:0] raw;
    logic signed [SUM_MAX_W-1:0] wrapped;
    logic signed [SUM_MAX_W-1:0] max_v;
    logic signed [SUM_MAX_W-1:0] min_v;
    int                          sh;
    raw     = a + b;
    sh      = SUM_MAX_W - w;
    wrapped = (raw <<< sh) >>> sh;
    max_v   = (32'sd1 <<< (w - 1)) - 32'sd1;
    min_v   = ~max_v;
    r.ovf   = (a[w-1] == b[w-1]) && (raw[w-1] != a[w-1]);
    if (r.ovf && sat_en) begin
      r.sum = a[w-1] ? min_v : max_v;
    end else begin
      r.sum = wrapped;
    end
    return r;
  endfunction

endpackage

// File: rtl/psum_out_buf.sv
// One-entry result register with valid/ready; a load in the draining cycle keeps valid high.
module psum_out_buf
  import pe_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [ACC_W-1:0] i_acc,
  input  logic [CNT_W-1:0] i_beats,
  input  logic             i_ovf,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [ACC_W-1:0] o_acc,
  output logic [CNT_W-1:0] o_beats,
  output logic             o_ovf
);

  logic             valid_q, valid_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic             ovf_q, ovf_d;

  // Load wins over drain; data only changes on a load so it is stable while stalled.
  always_comb begin
    valid_d = valid_q;
    acc_d   = acc_q;
    beats_d = beats_q;
    ovf_d   = ovf_q;
    if (i_load) begin
      valid_d = 1'b1;
      acc_d   = i_acc;
      beats_d = i_beats;
      ovf_d   = i_ovf;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  // Buffer registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      acc_q   <= '0;
      beats_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      acc_q   <= acc_d;
      beats_q <= beats_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_valid = valid_q;
  assign o_acc   = acc_q;
  assign o_beats = beats_q;
  assign o_ovf   = ovf_q;

endmodule

// File: rtl/fusion_psum_accumulator.sv
// Accumulates the PE shifted-product stream per group and hands one result per group downstream.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no group open; next accepted beat starts one
//   ST_ACCUM | group open; beats add into acc until a last beat closes it
module fusion_psum_accumulator
  import pe_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter bit SAT_EN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_prod_valid,
  input  logic [PROD_W-1:0] i_prod,
  input  logic              i_first,
  input  logic              i_last,
  output logic              o_prod_ready,
  output logic              o_acc_valid,
  output logic [ACC_W-1:0]  o_acc,
  output logic [CNT_W-1:0]  o_acc_beats,
  output logic              o_acc_ovf,
  input  logic              i_acc_ready,
  output logic              o_frame_err
);

  acc_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             frame_err_q, frame_err_d;
  logic             accept;
  logic             restart;
  logic             buf_load;
  sat_sum_t         add_r;

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next state: any accepted beat opens/continues a group unless it is the last.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = i_last ? ST_IDLE : ST_ACCUM;
    end
  end

  // Handshake, accumulate/restart datapath and framing-error tracking.
  always_comb begin
    // Ready is held low while in reset even though the buffer is already empty.
    o_prod_ready = i_rst_n & (~o_acc_valid | i_acc_ready);
    accept       = i_prod_valid & o_prod_ready;
    // A beat arriving in IDLE always starts a group, flagged or not.
    restart      = (state_q == ST_IDLE) | i_first;
    buf_load     = accept & i_last;
    add_r        = sat_add(SUM_MAX_W'(signed'(acc_q)), SUM_MAX_W'(signed'(i_prod)),
                           ACC_W, SAT_EN);
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    frame_err_d  = frame_err_q;
    if (accept) begin
      if (restart) begin
        acc_d       = ACC_W'(signed'(i_prod));
        cnt_d       = CNT_W'(1);
        ovf_d       = 1'b0;
        // Missing first in IDLE, or a stray first mid-group.
        frame_err_d = frame_err_q | ((state_q == ST_IDLE) ^ i_first);
      end else begin
        acc_d = ACC_W'(add_r.sum);
        cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        ovf_d = ovf_q | add_r.ovf;
      end
    end
  end

  assign o_frame_err = frame_err_q;

  psum_out_buf #(
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) u_out_buf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (buf_load),
    .i_acc   (acc_d),
    .i_beats (cnt_d),
    .i_ovf   (ovf_d),
    .i_ready (i_acc_ready),
    .o_valid (o_acc_valid),
    .o_acc   (o_acc),
    .o_beats (o_acc_beats),
    .o_ovf   (o_acc_ovf)
  );

endmodule

// File: tb/tb_fusion_psum_accumulator.sv
// Scoreboard bench: one 24-bit saturating DUT plus two 16-bit DUTs (saturate / wrap) on a shared stream.
module tb_fusion_psum_accumulator;

  typedef struct {
    int acc;
    int beats;
    int ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        prod_valid;
  logic [14:0] prod;
  logic        first;
  logic        last;
  logic        acc_ready;

  logic        rdy_m, v_m, ovf_m, ferr_m;
  logic [23:0] acc_m;
  logic [7:0]  beats_m;
  logic        rdy_s, v_s, ovf_s, ferr_s;
  logic [15:0] acc_s;
  logic [7:0]  beats_s;
  logic        rdy_w, v_w, ovf_w, ferr_w;
  logic [15:0] acc_w;
  logic [7:0]  beats_w;

  exp_t q_m[$];
  exp_t q_s[$];
  exp_t q_w[$];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fusion_psum_accumulator u_dut_m (
    .i_clk(clk), .i_rst_n(rst_n), .i_prod_valid(prod_valid), .i_prod(prod),
    .i_first(first), .i_last(last), .o_prod_ready(rdy_m), .o_acc_valid(v_m),
    .o_acc(acc_m), .o_acc_beats(beats_m), .o_acc_ovf(ovf_m),
    .i_acc_ready(acc_ready), .o_frame_err(ferr_m));

  fusion_psum_accumulator #(.ACC_W(16), .SAT_EN(1'b1)) u_dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_prod_valid(prod_valid), .i_prod(prod),
    .i_first(first), .i_last(last), .o_prod_ready(rdy_s), .o_acc_valid(v_s),
    .o_acc(acc_s), .o_acc_beats(beats_s), .o_acc_ovf(ovf_s),
    .i_acc_ready(acc_ready), .o_frame_err(ferr_s));

  fusion_psum_accumulator #(.ACC_W(16), .SAT_EN(1'b0)) u_dut_w (
    .i_clk(clk), .i_rst_n(rst_n), .i_prod_valid(prod_valid), .i_prod(prod),
    .i_first(first), .i_last(last), .o_prod_ready(rdy_w), .o_acc_valid(v_w),
    .o_acc(acc_w), .o_acc_beats(beats_w), .o_acc_ovf(ovf_w),
    .i_acc_ready(acc_ready), .o_frame_err(ferr_w));

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int a_m, input int a_s, input int a_w, input int b,
                          input int o_m, input int o_s, input int o_w);
    q_m.push_back('{acc: a_m, beats: b, ovf: o_m});
    q_s.push_back('{acc: a_s, beats: b, ovf: o_s});
    q_w.push_back('{acc: a_w, beats: b, ovf: o_w});
  endtask

  task automatic push_all(input int a, input int b);
    push_exp(a, a, a, b, 0, 0, 0);
  endtask

  // Called at a falling edge; returns at the falling edge after the beat is taken.
  task automatic send(input int p, input bit f, input bit l);
    bit taken;
    taken      = 1'b0;
    prod_valid = 1'b1;
    prod       = 15'(p);
    first      = f;
    last       = l;
    for (int n = 0; n < 200 && !taken; n++) begin
      #2;
      taken = rdy_m;
      @(posedge clk);
      @(negedge clk);
    end
    if (!taken) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: got not_accepted expected accepted (prod %0d)", p);
    end
    prod_valid = 1'b0;
    first      = 1'b0;
    last       = 1'b0;
  endtask

  // Monitor: a transfer happens on the coming rising edge when valid & ready late in the cycle.
  always @(negedge clk) begin
    exp_t e;
    #4;
    if (rst_n) begin
      if (v_m && acc_ready) begin
        if (q_m.size() == 0) chk("main_unexpected_result", 1, 0);
        else begin
          e = q_m.pop_front();
          chk("main_acc", $signed(acc_m), e.acc);
          chk("main_beats", int'(beats_m), e.beats);
          chk("main_ovf", int'(ovf_m), e.ovf);
        end
      end
      if (v_s && acc_ready) begin
        if (q_s.size() == 0) chk("sat16_unexpected_result", 1, 0);
        else begin
          e = q_s.pop_front();
          chk("sat16_acc", $signed(acc_s), e.acc);
          chk("sat16_beats", int'(beats_s), e.beats);
          chk("sat16_ovf", int'(ovf_s), e.ovf);
        end
      end
      if (v_w && acc_ready) begin
        if (q_w.size() == 0) chk("wrap16_unexpected_result", 1, 0);
        else begin
          e = q_w.pop_front();
          chk("wrap16_acc", $signed(acc_w), e.acc);
          chk("wrap16_beats", int'(beats_w), e.beats);
          chk("wrap16_ovf", int'(ovf_w), e.ovf);
        end
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    prod_valid = 1'b0;
    prod       = '0;
    first      = 1'b0;
    last       = 1'b0;
    acc_ready  = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_prod_ready", int'(rdy_m), 0);
    chk("rst_acc_valid", int'(v_m), 0);
    chk("rst_acc", int'(acc_m), 0);
    chk("rst_frame_err", int'(ferr_m), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", int'(rdy_m), 1);
    @(negedge clk);

    // 4-beat group, result exactly one cycle after the last beat
    push_all(58, 4);
    send(100, 1, 0);
    send(-50, 0, 0);
    send(7, 0, 0);
    chk("t1_no_early_valid", int'(v_m), 0);
    send(1, 0, 1);
    chk("t1_valid_latency", int'(v_m), 1);

    // Single-beat group at the negative product limit, then an immediate next group
    push_all(-16384, 1);
    send(-16384, 1, 1);
    chk("t2_valid_latency", int'(v_m), 1);
    chk("t2_ready_while_draining", int'(rdy_m), 1);
    push_all(8, 2);
    send(5, 1, 0);
    send(3, 0, 1);

    // Back-to-back last beats keep valid high with no bubble
    push_all(11, 1);
    push_all(22, 1);
    send(11, 1, 1);
    send(22, 1, 1);
    chk("b2b_valid_held", int'(v_m), 1);
    chk("b2b_second_value", $signed(acc_m), 22);
    @(negedge clk);
    chk("b2b_drained", int'(v_m), 0);

    // Backpressure: held result blocks the next group until downstream is ready
    acc_ready = 1'b0;
    push_all(8, 2);
    send(5, 1, 0);
    send(3, 0, 1);
    push_all(50, 2);
    fork
      begin
        send(20, 1, 0);
        send(30, 0, 1);
      end
      begin
        repeat (3) begin
          #2;
          chk("bp_prod_ready_low", int'(rdy_m), 0);
          chk("bp_prod_ready_low_16", int'(rdy_s | rdy_w), 0);
          chk("bp_acc_stable", $signed(acc_m), 8);
          chk("bp_valid_held", int'(v_m), 1);
          @(negedge clk);
        end
        #1;
        acc_ready = 1'b1;
      end
    join
    @(negedge clk);
    chk("no_frame_err_yet", int'(ferr_m), 0);

    // Overflow: 24-bit holds 48000; 16-bit saturates or wraps
    push_exp(48000, 32767, -17536, 3, 0, 1, 1);
    send(16000, 1, 0);
    send(16000, 0, 0);
    send(16000, 0, 1);
    push_all(2, 1);
    send(2, 1, 1);

    // Beat counter saturates at 255
    push_all(300, 255);
    for (int i = 0; i < 300; i++) send(1, i == 0, i == 299);

    // Framing: missing first from IDLE still starts a group
    push_all(10, 2);
    send(9, 0, 0);
    send(1, 0, 1);
    chk("frame_err_missing_first", int'(ferr_m), 1);
    chk("frame_err_16", int'(ferr_s & ferr_w), 1);

    // Framing: first mid-group discards the partial sum
    push_all(7, 2);
    send(10, 1, 0);
    send(20, 0, 0);
    send(3, 1, 0);
    send(4, 0, 1);
    chk("frame_err_sticky", int'(ferr_m), 1);

    // Async reset mid-group
    repeat (3) @(negedge clk);
    send(1, 1, 0);
    send(2, 0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_acc", int'(acc_m), 0);
    chk("arst_beats", int'(beats_m), 0);
    chk("arst_valid", int'(v_m), 0);
    chk("arst_prod_ready", int'(rdy_m), 0);
    chk("arst_frame_err", int'(ferr_m), 0);
    @(negedge clk);
    rst_n = 1'b1;
    push_all(3, 2);
    send(1, 1, 0);
    send(2, 0, 1);
    chk("post_reset_frame_err", int'(ferr_m), 0);

    for (int n = 0; n < 50 && (q_m.size() + q_s.size() + q_w.size()) != 0; n++)
      @(negedge clk);
    @(negedge clk);
    chk("scoreboard_empty", q_m.size() + q_s.size() + q_w.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fusion_psum_accumulator.md
Name: fusion_psum_accumulator

Overview:
- Downstream stage of the 2-bit-brick fused PE. Consumes the PE's registered 15-bit signed shifted product stream and accumulates one product per cycle across a group of beats. A group is the set of shift-amount passes that make up one wide-precision dot product.
- Emits one ACC_W-bit signed result per group through a valid/ready handshake, with a 1-entry output buffer. It also reports overflow and framing errors.
- Sits between the PE array column and the output writeback/requantiser.

Parameters:
- PROD_W, 15, width of the signed input product (matches PE output).
- ACC_W, 24, width of the signed accumulator and result.
- CNT_W, 8, width of the beat counter (saturates at 2^CNT_W-1).
- SAT_EN, 1, 1 = clamp to ACC_W signed min/max on overflow; 0 = two's-complement wrap.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_prod_valid  in  1  i_prod carries a beat this cycle.
- i_prod  in  PROD_W  signed product from PE (already shifted).
- i_first  in  1  beat is the first of a group.
- i_last  in  1  beat is the last of a group.
- o_prod_ready  out  1  block accepts a beat this cycle.
- o_acc_valid  out  1  result buffer holds a result.
- o_acc  out  ACC_W  signed group result.
- o_acc_beats  out  CNT_W  number of beats in the reported group.
- o_acc_ovf  out  1  overflow occurred in the reported group.
- i_acc_ready  in  1  downstream takes the result.
- o_frame_err  out  1  sticky framing-error flag; cleared only by reset.

Behaviour:
- Clock is i_clk; reset is asynchronous, active-low, on i_rst_n. The polarity and synchronicity are fixed.
- Reset values: all outputs 0, o_prod_ready 0 during reset, FSM in IDLE, accumulator 0, counter 0, ovf flag 0.
- Beat acceptance: accept = i_prod_valid & o_prod_ready.
- o_prod_ready = ~o_acc_valid | i_acc_ready. It is combinational and outside reset equals 1 when the buffer is empty or draining this cycle.
- Sign extension: i_prod is sign-extended to ACC_W before every add.
- Overflow detection: two operands of equal sign giving a sum of different sign.
- SAT_EN=1 saturation: clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1). The clamped value becomes the new accumulator.
- FSM IDLE:
  - Accept with i_first loads acc=sext(prod), cnt=1, ovf=0, and goes to ACCUM.
  - Accept without i_first is treated as i_first and also sets o_frame_err.
- FSM ACCUM:
  - Accept with i_first: restart (load as above) and set o_frame_err; the partial group is discarded.
  - Otherwise acc+=prod, cnt+=1 (saturating), and ovf |= overflow.
- Last beat:
  - Any accepted beat with i_last (including first&last on one beat) writes the updated acc/cnt/ovf into the output buffer in the same edge. o_acc_valid becomes 1 the next cycle and the FSM goes to IDLE.
  - Latency is 1 cycle from accepting the last beat to o_acc_valid.
- Output buffer:
  - o_acc/o_acc_beats/o_acc_ovf are stable while o_acc_valid & ~i_acc_ready.
  - On o_acc_valid & i_acc_ready with no new last beat, o_acc_valid clears next cycle.
  - If a last beat is accepted in the same cycle the buffer drains, the buffer reloads and o_acc_valid stays 1, giving back-to-back results with no bubble.
- Stall: when o_prod_ready=0 no beat is consumed and acc/cnt hold. The upstream must hold i_prod/i_first/i_last/i_prod_valid stable.
- i_prod_valid=0: no state change except buffer drain.

Decomposition:
- Shared package (pe_pkg):
  - PROD_W and ACC_W defaults.
  - FSM state encoding {IDLE, ACCUM}.
  - A sat_add function returning {sum, ovf} for the given widths.
- One natural sub-module, psum_out_buf: the 1-entry valid/ready result register with simultaneous load/drain. The FSM, accumulator and counter stay in the top.

Test Plan:
- 4-beat group, ready high. Beats: 100 first, -50, 7, 1 last. Required: o_acc=58, beats=4, ovf=0, o_acc_valid one cycle after the last beat.
- Single-beat group with first&last and prod=-16384. Required: o_acc=-16384, beats=1. Then an immediate next group (5 first, 3 last) gives 8 with no bubble.
- Backpressure. Hold i_acc_ready=0 after a result is produced. Required: o_prod_ready=0, the next group's beats are not consumed, and o_acc is stable. Raising ready drains the result and the next group completes correctly.
- Overflow, ACC_W=16, SAT_EN=1. Beats: 16000 first, 16000, 16000 last. Required: o_acc=32767, ovf=1. With SAT_EN=0, o_acc wraps to -17536 and ovf=1.
- Framing errors:
  - Beat 9 without i_first from IDLE: o_frame_err=1 and the group still sums from 9.
  - i_first mid-group (10 first, 20, then 3 first, 4 last): o_acc=7.
- Async reset mid-group (after 2 of 4 beats). Required: outputs go to 0 immediately. After release, a fresh group 1 first, 2 last gives o_acc=3 and o_frame_err=0.
